// File: rtl/cp0_exception_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exception_unit
//  Description : Coprocessor-0 responder for the pipelined MIPS core.
//                Holds STATUS, CAUSE and EPC, sequences exception entry
//                and return (eret), and drives a one-cycle PC redirect
//                and pipeline flush. STATUS is exported to the decoder
//                for exception gating.
//  Ports       : clk, rst          clock / synchronous active-high reset
//                exception_i       take exception (pre-gated by decoder)
//                eret_i            return from exception
//                mfc0_i, mtc0_i    CP0 read / write strobes
//                cause_in_i[4:0]   exception code
//                cp0_addr_i[4:0]   12=STATUS 13=CAUSE 14=EPC
//                wdata_i[31:0]     mtc0 write data
//                pc_i[31:0]        PC of the excepting instruction
//                rdata_o[31:0]     mfc0 read data (combinational)
//                status_o[31:0]    live STATUS register
//                exc_addr_o[31:0]  redirect target
//                redirect_o        load exc_addr_o into PC this cycle
//                flush_o           squash younger pipeline stages
//                busy_o            sequencer not idle; requests ignored
//                nest_overflow_o   sticky: nesting went past MAX_NEST
//  Revision    : 1.0  initial release
// ============================================================================
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter logic [31:0] STATUS_RESET = 32'h0000_000F,
    parameter int          MAX_NEST     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception_i,
    input  logic        eret_i,
    input  logic        mfc0_i,
    input  logic        mtc0_i,
    input  logic [4:0]  cause_in_i,
    input  logic [4:0]  cp0_addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] pc_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] exc_addr_o,
    output logic        redirect_o,
    output logic        flush_o,
    output logic        busy_o,
    output logic        nest_overflow_o
);

    localparam int                 DEPTH_W   = $clog2(MAX_NEST + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_NEST);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_LEAVE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [31:0]         status_q, status_d;
    logic [31:0]         cause_q,  cause_d;
    logic [31:0]         epc_q,    epc_d;
    logic [DEPTH_W-1:0]  depth_q,  depth_d;
    logic                ovf_q,    ovf_d;

    // ------------------------------------------------------------------
    // State and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            status_q <= STATUS_RESET;
            cause_q  <= 32'h0;
            epc_q    <= 32'h0;
            depth_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            depth_q  <= depth_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Requests are only accepted in IDLE; priority is
    // exception > eret > mtc0, so a colliding mtc0 is simply dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (exception_i) begin
                    epc_d    = pc_i;
                    cause_d  = {cause_q[31:7], cause_in_i, cause_q[1:0]};
                    // Interrupt-enable stack: push the current mask field.
                    status_d = status_q << 5;
                    if (depth_q == DEPTH_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        depth_d = depth_q + DEPTH_ONE;
                    end
                    state_d  = ST_ENTER;
                end else if (eret_i) begin
                    // An unmatched eret still redirects but leaves STATUS alone.
                    if (depth_q != '0) begin
                        status_d = status_q >> 5;
                        depth_d  = depth_q - DEPTH_ONE;
                    end
                    state_d = ST_LEAVE;
                end else if (mtc0_i) begin
                    case (cp0_addr_i)
                        ADDR_STATUS: status_d = wdata_i;
                        ADDR_CAUSE:  cause_d  = wdata_i;
                        ADDR_EPC:    epc_d    = wdata_i;
                        default:     ;
                    endcase
                end
            end
            ST_ENTER: state_d = ST_IDLE;
            ST_LEAVE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs decode from the state register only.
    // ------------------------------------------------------------------
    always_comb begin
        redirect_o = 1'b0;
        flush_o    = 1'b0;
        busy_o     = 1'b0;
        exc_addr_o = 32'h0;
        case (state_q)
            ST_ENTER: begin
                redirect_o = 1'b1;
                flush_o    = 1'b1;
                busy_o     = 1'b1;
                exc_addr_o = EXC_VECTOR;
            end
            ST_LEAVE: begin
                redirect_o = 1'b1;
                flush_o    = 1'b1;
                busy_o     = 1'b1;
                exc_addr_o = epc_q;
            end
            default: ;
        endcase
    end

    // Read port sees registered values only (no same-cycle mtc0 bypass).
    always_comb begin
        rdata_o = 32'h0;
        if (mfc0_i) begin
            case (cp0_addr_i)
                ADDR_STATUS: rdata_o = status_q;
                ADDR_CAUSE:  rdata_o = cause_q;
                ADDR_EPC:    rdata_o = epc_q;
                default:     rdata_o = 32'h0;
            endcase
        end
    end

    assign status_o        = status_q;
    assign nest_overflow_o = ovf_q;

endmodule
`default_nettype wire
